// File: rtl/io_bank_shadow.sv
// I/O pad bank configured through a serial chain with a shadow register.
// The chain loads the shadow; an accepted commit copies it to the pads.
module io_bank_shadow #(
    parameter int SIZE     = 5,
    parameter int CFG_BITS = 4
) (
    input  logic            prog_clk,
    input  logic            prog_rst,
    input  logic            prog_in,
    input  logic            prog_en,
    input  logic            prog_commit,
    output logic            prog_out,
    output logic            prog_done,
    output logic            commit_ack,
    output logic            cfg_err,
    input  logic [SIZE-1:0] fpga_out,
    input  logic [SIZE-1:0] fpga_oe,
    output logic [SIZE-1:0] fpga_in,
    input  logic [SIZE-1:0] pad_in,
    output logic [SIZE-1:0] pad_out,
    output logic [SIZE-1:0] pad_oe
);

    localparam int L  = SIZE * CFG_BITS;
    localparam int CW = $clog2(L + 1);
    localparam logic [CW-1:0] FULL = CW'(L);

    if (CFG_BITS != 4) begin : g_bad_cfg
        $error("io_bank_shadow: CFG_BITS must be 4");
    end

    logic [L-1:0]    shadow;
    logic [L-1:0]    active;
    logic [CW-1:0]   count;
    logic [SIZE-1:0] q;
    logic [SIZE-1:0] q_nxt;
    logic            commit_ok;
    logic            commit_bad;

    // A commit racing a shift would copy a frame that is about to move.
    assign commit_ok  = prog_commit & ~prog_en & (count == FULL);
    assign commit_bad = prog_commit & ~commit_ok;

    assign prog_out  = shadow[L-1];
    assign prog_done = (count == FULL);

    always_ff @(posedge prog_clk or posedge prog_rst) begin
        if (prog_rst) begin
            shadow     <= '0;
            active     <= '0;
            count      <= '0;
            cfg_err    <= 1'b0;
            commit_ack <= 1'b0;
            q          <= '0;
        end else begin
            commit_ack <= commit_ok;
            q          <= q_nxt;
            if (prog_en) begin
                shadow <= {shadow[L-2:0], prog_in};
                if (count != FULL) begin
                    count <= count + CW'(1);
                end
            end else if (commit_ok) begin
                active <= shadow;
                count  <= '0;
            end
            if (commit_bad) begin
                cfg_err <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < SIZE; i++) begin : g_pad
        logic [1:0] mode;
        logic       rg;
        logic       inv;
        logic       d;

        assign mode = active[i*CFG_BITS +: 2];
        assign rg   = active[i*CFG_BITS + 2];
        assign inv  = active[i*CFG_BITS + 3];
        assign d    = pad_in[i] ^ inv;

        assign pad_out[i] = fpga_out[i] ^ inv;
        assign pad_oe[i]  = (mode == 2'b10) |
                            ((mode == 2'b11) & fpga_oe[i]);
        // mode[0] set means the receiver is enabled (input or bidir).
        assign q_nxt[i]   = mode[0] & d;
        assign fpga_in[i] = mode[0] & (rg ? q[i] : d);
    end

endmodule

// File: tb/tb_io_bank_shadow.sv
// Scoreboard bench for io_bank_shadow with a two-pad bank.
// Chain bits are queued on shift and popped against prog_out.
module tb_io_bank_shadow;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       prog_in = 1'b0;
    logic       prog_en = 1'b0;
    logic       prog_commit = 1'b0;
    logic       prog_out;
    logic       prog_done;
    logic       commit_ack;
    logic       cfg_err;
    logic [1:0] fpga_out = 2'b00;
    logic [1:0] fpga_oe = 2'b00;
    logic [1:0] fpga_in;
    logic [1:0] pad_in = 2'b00;
    logic [1:0] pad_out;
    logic [1:0] pad_oe;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_shadow;
    logic [7:0] m_active;
    int         m_cnt;
    logic       m_err;
    logic       sb[$];

    always #5 clk = ~clk;

    io_bank_shadow #(.SIZE(2), .CFG_BITS(4)) dut (
        .prog_clk    (clk),
        .prog_rst    (rst),
        .prog_in     (prog_in),
        .prog_en     (prog_en),
        .prog_commit (prog_commit),
        .prog_out    (prog_out),
        .prog_done   (prog_done),
        .commit_ack  (commit_ack),
        .cfg_err     (cfg_err),
        .fpga_out    (fpga_out),
        .fpga_oe     (fpga_oe),
        .fpga_in     (fpga_in),
        .pad_in      (pad_in),
        .pad_out     (pad_out),
        .pad_oe      (pad_oe)
    );

    function automatic logic [1:0] f_oe(logic [7:0] a, logic [1:0] oe);
        logic [1:0] r;
        r = 2'b00;
        for (int i = 0; i < 2; i++) begin
            case (a[4*i +: 2])
                2'b10:   r[i] = 1'b1;
                2'b11:   r[i] = oe[i];
                default: r[i] = 1'b0;
            endcase
        end
        return r;
    endfunction

    function automatic logic [1:0] f_out(logic [7:0] a, logic [1:0] fo);
        return fo ^ {a[7], a[3]};
    endfunction

    task automatic model_reset();
        m_shadow = 8'h00;
        m_active = 8'h00;
        m_cnt    = 0;
        m_err    = 1'b0;
        sb.delete();
    endtask

    task automatic shift(input logic b);
        logic exp_out;
        prog_en = 1'b1;
        prog_in = b;
        @(posedge clk);
        #1;
        prog_en = 1'b0;
        m_shadow = {m_shadow[6:0], b};
        if (m_cnt < 8) m_cnt++;
        sb.push_back(b);
        if (sb.size() > 8) void'(sb.pop_front());
        exp_out = (sb.size() == 8) ? sb[0] : 1'b0;
        checks++;
        if (prog_out !== exp_out) begin
            errors++;
            $display("FAIL shift_prog_out got %b want %b", prog_out, exp_out);
        end
        checks++;
        if (prog_done !== (m_cnt == 8)) begin
            errors++;
            $display("FAIL shift_done got %b want %b", prog_done, m_cnt == 8);
        end
        checks++;
        if (pad_oe !== f_oe(m_active, fpga_oe)) begin
            errors++;
            $display("FAIL shift_pad_oe got %b want %b",
                     pad_oe, f_oe(m_active, fpga_oe));
        end
    endtask

    task automatic shift_frame(input logic [7:0] f);
        for (int i = 7; i >= 0; i--) shift(f[i]);
    endtask

    task automatic commit();
        logic ok;
        ok = (m_cnt == 8);
        prog_en = 1'b0;
        prog_commit = 1'b1;
        @(posedge clk);
        #1;
        prog_commit = 1'b0;
        if (ok) begin
            m_active = m_shadow;
            m_cnt = 0;
        end else begin
            m_err = 1'b1;
        end
        checks++;
        if (commit_ack !== ok) begin
            errors++;
            $display("FAIL commit_ack got %b want %b", commit_ack, ok);
        end
        checks++;
        if (cfg_err !== m_err) begin
            errors++;
            $display("FAIL commit_err got %b want %b", cfg_err, m_err);
        end
        checks++;
        if (prog_done !== (m_cnt == 8)) begin
            errors++;
            $display("FAIL commit_done got %b want %b", prog_done, m_cnt == 8);
        end
        checks++;
        if (pad_oe !== f_oe(m_active, fpga_oe)) begin
            errors++;
            $display("FAIL commit_pad_oe got %b want %b",
                     pad_oe, f_oe(m_active, fpga_oe));
        end
        checks++;
        if (pad_out !== f_out(m_active, fpga_out)) begin
            errors++;
            $display("FAIL commit_pad_out got %b want %b",
                     pad_out, f_out(m_active, fpga_out));
        end
        @(posedge clk);
        #1;
        checks++;
        if (commit_ack !== 1'b0) begin
            errors++;
            $display("FAIL ack_pulse got %b want 0", commit_ack);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        prog_en = 1'b0;
        prog_commit = 1'b0;
        pad_in = 2'b11;
        fpga_out = 2'b10;
        model_reset();
        #1;
        checks++;
        if ({pad_oe, fpga_in} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_pads got oe=%b in=%b want 00 00", pad_oe, fpga_in);
        end
        checks++;
        if ({prog_done, cfg_err, prog_out, commit_ack} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b%b%b%b want 0000",
                     prog_done, cfg_err, prog_out, commit_ack);
        end
        checks++;
        if (pad_out !== fpga_out) begin
            errors++;
            $display("FAIL reset_pad_out got %b want %b", pad_out, fpga_out);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        pad_in = 2'b00;
    endtask

    task automatic test_program_commit();
        fpga_out = 2'b01;
        shift_frame(8'b0000_0110);
        commit();
        checks++;
        if (pad_oe !== 2'b01 || pad_out !== 2'b01) begin
            errors++;
            $display("FAIL prog_pads got oe=%b out=%b want 01 01", pad_oe, pad_out);
        end
        fpga_out = 2'b10;
        #1;
        checks++;
        if (pad_out !== 2'b10) begin
            errors++;
            $display("FAIL prog_follow got %b want 10", pad_out);
        end
    endtask

    task automatic test_early_commit();
        for (int i = 0; i < 5; i++) shift(1'(i & 1));
        commit();
        checks++;
        if (cfg_err !== 1'b1 || pad_oe !== 2'b01) begin
            errors++;
            $display("FAIL early got err=%b oe=%b want 1 01", cfg_err, pad_oe);
        end
    endtask

    task automatic test_bidir();
        pad_in = 2'b00;
        fpga_oe = 2'b00;
        shift_frame(8'b1111_0110);
        commit();
        fpga_oe = 2'b10;
        #1;
        checks++;
        if (pad_oe !== 2'b11) begin
            errors++;
            $display("FAIL bidir_oe_on got %b want 11", pad_oe);
        end
        fpga_oe = 2'b00;
        fpga_out = 2'b10;
        #1;
        checks++;
        if (pad_oe !== 2'b01 || pad_out !== 2'b00) begin
            errors++;
            $display("FAIL bidir_oe_off got oe=%b out=%b want 01 00", pad_oe, pad_out);
        end
        checks++;
        if (fpga_in !== 2'b10) begin
            errors++;
            $display("FAIL bidir_q_idle got %b want 10", fpga_in);
        end
        pad_in = 2'b10;
        #1;
        checks++;
        if (fpga_in !== 2'b10) begin
            errors++;
            $display("FAIL bidir_latency got %b want 10", fpga_in);
        end
        @(posedge clk);
        #1;
        checks++;
        if (fpga_in !== 2'b00) begin
            errors++;
            $display("FAIL bidir_in got %b want 00", fpga_in);
        end
    endtask

    task automatic test_shift_through();
        fpga_oe = 2'b10;
        for (int i = 0; i < 12; i++) shift(1'($urandom_range(0, 1)));
        checks++;
        if (prog_done !== 1'b1 || pad_oe !== 2'b11) begin
            errors++;
            $display("FAIL through got done=%b oe=%b want 1 11", prog_done, pad_oe);
        end
    endtask

    task automatic test_simultaneous();
        test_reset();
        shift_frame(8'b0110_1011);
        commit();
        for (int i = 0; i < 8; i++) shift(1'($urandom_range(0, 1)));
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL simul_pre_err got %b want 0", cfg_err);
        end
        prog_en = 1'b1;
        prog_commit = 1'b1;
        prog_in = ~sb[1];
        @(posedge clk);
        #1;
        m_shadow = {m_shadow[6:0], prog_in};
        sb.push_back(prog_in);
        void'(sb.pop_front());
        prog_en = 1'b0;
        prog_commit = 1'b0;
        checks++;
        if (commit_ack !== 1'b0 || cfg_err !== 1'b1) begin
            errors++;
            $display("FAIL simul_flags got ack=%b err=%b want 0 1", commit_ack, cfg_err);
        end
        checks++;
        if (prog_out !== sb[0] || prog_done !== 1'b1) begin
            errors++;
            $display("FAIL simul_shift got out=%b done=%b want %b 1",
                     prog_out, prog_done, sb[0]);
        end
        checks++;
        if (pad_oe !== f_oe(m_active, fpga_oe) || pad_out !== f_out(m_active, fpga_out)) begin
            errors++;
            $display("FAIL simul_pads got oe=%b out=%b", pad_oe, pad_out);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) shift(1'b1);
        prog_en = 1'b1;
        pad_in = 2'b11;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({pad_oe, fpga_in, prog_done, prog_out, cfg_err} !== 7'b0) begin
            errors++;
            $display("FAIL mid_reset got oe=%b in=%b done=%b out=%b err=%b",
                     pad_oe, fpga_in, prog_done, prog_out, cfg_err);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        prog_en = 1'b0;
        fpga_out = 2'b01;
        shift_frame(8'b1000_0010);
        commit();
        checks++;
        if (pad_oe !== 2'b01 || pad_out !== 2'b11) begin
            errors++;
            $display("FAIL mid_reprog got oe=%b out=%b want 01 11", pad_oe, pad_out);
        end
    endtask

    initial begin
        test_reset();
        test_program_commit();
        test_early_commit();
        test_bidir();
        test_shift_through();
        test_simultaneous();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
